cam_controller: RTL and testbench

//  Sequences a CAM array (CAM_WIDTH x CAM_DEPTH, one-hot row write enables, per-row match lines).

---
 rtl/cam_ctrl_pkg.sv | 24 ++
 rtl/cam_priority_encoder.sv | 25 ++
 rtl/cam_controller.sv | 183 ++++++++++++++++++
 tb/tb_cam_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and width helper for the CAM controller.
package cam_ctrl_pkg;

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_ALLOC  = 2'b10;
  localparam logic [1:0] OP_INVAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Never returns less than 1 so single-entry vectors still get a legal width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cam_priority_encoder.sv
// Lowest-set-bit index of a vector plus an any-bit-set flag.
module cam_priority_encoder
  import cam_ctrl_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scanning high to low leaves the lowest set index as the final assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_controller.sv
// CAM sequencer: search / write / allocate / invalidate with row-occupancy tracking.
// Optional rsp_multi output is enabled by defining CAM_CTRL_MULTI_MATCH_EN.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_SEARCH | key on array, waiting CAM_LATENCY cycles for match lines
// ST_WRITE  | one-cycle write/invalidate/error slot
// ST_RESP   | response pulse cycle
module cam_controller
  import cam_ctrl_pkg::*;
#(
  parameter  int CAM_WIDTH   = 8,
  parameter  int CAM_DEPTH   = 8,
  parameter  int CAM_LATENCY = 1,
  localparam int ADDR_W      = clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [CAM_WIDTH-1:0] req_word,
  input  logic [CAM_WIDTH-1:0] req_mask,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [ADDR_W-1:0]    rsp_addr,
  output logic                 rsp_err,
  output logic [CAM_DEPTH-1:0] cam_we,
  output logic [CAM_WIDTH-1:0] cam_search_word,
  output logic [CAM_WIDTH-1:0] cam_dont_care_mask,
  input  logic [CAM_DEPTH-1:0] cam_match,
`ifdef CAM_CTRL_MULTI_MATCH_EN
  output logic                 rsp_multi,
`endif
  output logic [ADDR_W:0]      occupancy
);

  localparam int LAT_W = clog2(CAM_LATENCY + 1);

  state_t               state;
  logic [CAM_DEPTH-1:0] valid;
  logic [LAT_W-1:0]     lat_cnt;
  logic [ADDR_W-1:0]    addr_q;
  logic                 err_q;

  logic [CAM_DEPTH-1:0] hit_vec;
  logic [ADDR_W-1:0]    hit_idx;
  logic                 hit_any;
  logic [ADDR_W-1:0]    free_idx;
  logic                 free_any;
  logic                 addr_oob;
  logic                 accept;

  assign hit_vec  = cam_match & valid;
  assign addr_oob = {1'b0, req_addr} >= (ADDR_W + 1)'(CAM_DEPTH);
  assign accept   = req_valid & req_ready;

  cam_priority_encoder #(.N(CAM_DEPTH)) u_hit_enc (
    .vec(hit_vec),
    .idx(hit_idx),
    .any(hit_any)
  );

  cam_priority_encoder #(.N(CAM_DEPTH)) u_free_enc (
    .vec(~valid),
    .idx(free_idx),
    .any(free_any)
  );

`ifdef CAM_CTRL_MULTI_MATCH_EN
  logic multi_hit;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hit = |(hit_vec & (hit_vec - CAM_DEPTH'(1)));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      req_ready          <= 1'b1;
      rsp_valid          <= 1'b0;
      rsp_hit            <= 1'b0;
      rsp_addr           <= '0;
      rsp_err            <= 1'b0;
      cam_we             <= '0;
      cam_search_word    <= '0;
      cam_dont_care_mask <= '0;
      valid              <= '0;
      occupancy          <= '0;
      lat_cnt            <= '0;
      addr_q             <= '0;
      err_q              <= 1'b0;
`ifdef CAM_CTRL_MULTI_MATCH_EN
      rsp_multi          <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready          <= 1'b0;
            cam_search_word    <= req_word;
            cam_dont_care_mask <= req_mask;
            addr_q             <= req_addr;
            err_q              <= 1'b0;
            state              <= ST_WRITE;
            case (req_op)
              OP_SEARCH: begin
                lat_cnt <= LAT_W'(CAM_LATENCY);
                state   <= ST_SEARCH;
              end
              OP_WRITE: begin
                if (addr_oob) begin
                  err_q <= 1'b1;
                end else begin
                  cam_we          <= CAM_DEPTH'(1) << req_addr;
                  valid[req_addr] <= 1'b1;
                  if (!valid[req_addr] && occupancy < (ADDR_W + 1)'(CAM_DEPTH))
                    occupancy <= occupancy + (ADDR_W + 1)'(1);
                end
              end
              OP_ALLOC: begin
                if (free_any) begin
                  addr_q          <= free_idx;
                  cam_we          <= CAM_DEPTH'(1) << free_idx;
                  valid[free_idx] <= 1'b1;
                  if (occupancy < (ADDR_W + 1)'(CAM_DEPTH))
                    occupancy <= occupancy + (ADDR_W + 1)'(1);
                end else begin
                  addr_q <= '0;
                  err_q  <= 1'b1;
                end
              end
              OP_INVAL: begin
                if (addr_oob) begin
                  err_q <= 1'b1;
                end else begin
                  valid[req_addr] <= 1'b0;
                  if (valid[req_addr] && occupancy != '0)
                    occupancy <= occupancy - (ADDR_W + 1)'(1);
                end
              end
            endcase
          end
        end
        ST_SEARCH: begin
          if (lat_cnt == '0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= hit_any;
            rsp_addr  <= hit_idx;
            rsp_err   <= 1'b0;
`ifdef CAM_CTRL_MULTI_MATCH_EN
            rsp_multi <= multi_hit;
`endif
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_WRITE: begin
          cam_we    <= '0;
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_addr  <= addr_q;
          rsp_err   <= err_q;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_hit   <= 1'b0;
          rsp_addr  <= '0;
          rsp_err   <= 1'b0;
`ifdef CAM_CTRL_MULTI_MATCH_EN
          rsp_multi <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_controller.sv
// Directed bench for cam_controller with a behavioural CAM array model (1-cycle match latency).
module tb_cam_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_addr;
  logic [7:0] req_word;
  logic [7:0] req_mask;
  logic       rsp_valid;
  logic       rsp_hit;
  logic [2:0] rsp_addr;
  logic       rsp_err;
  logic [7:0] cam_we;
  logic [7:0] cam_search_word;
  logic [7:0] cam_dont_care_mask;
  logic [7:0] cam_match;
  logic       rsp_multi;
  logic [3:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  cam_controller #(.CAM_WIDTH(8), .CAM_DEPTH(8), .CAM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_word(req_word), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .cam_we(cam_we), .cam_search_word(cam_search_word),
    .cam_dont_care_mask(cam_dont_care_mask), .cam_match(cam_match),
`ifdef CAM_CTRL_MULTI_MATCH_EN
    .rsp_multi(rsp_multi),
`endif
    .occupancy(occupancy)
  );

`ifndef CAM_CTRL_MULTI_MATCH_EN
  assign rsp_multi = 1'b0;
`endif

  always #5 clk = ~clk;

  // Array model: rows power up holding 0xA5 so unwritten rows would match unless masked.
  logic [7:0] store [8];
  int we_cnt = 0;
  int we_multi_hot = 0;
  initial for (int r = 0; r < 8; r++) store[r] = 8'hA5;

  always @(posedge clk) begin
    if (cam_we != 8'h00) begin
      we_cnt <= we_cnt + 1;
      if ($countones(cam_we) > 1) we_multi_hot <= we_multi_hot + 1;
      for (int r = 0; r < 8; r++) if (cam_we[r]) store[r] <= cam_search_word;
    end
    for (int r = 0; r < 8; r++)
      cam_match[r] <= (((store[r] ^ cam_search_word) & ~cam_dont_care_mask) == 8'h00);
  end

  // Results of the last request
  int         lat;
  logic       r_hit, r_err, r_multi, r_dirty;
  logic [2:0] r_addr;
  int         we_delta;

  localparam logic [1:0] SRCH = 2'b00, WR = 2'b01, AL = 2'b10, INV = 2'b11;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [2:0] addr,
                        input logic [7:0] word, input logic [7:0] mask);
    int  n;
    int  we0;
    bit  got;
    n = 0;
    got = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_word = word; req_mask = mask;
    we0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (rsp_valid) begin
        got = 1; lat = i;
        r_hit = rsp_hit; r_addr = rsp_addr; r_err = rsp_err; r_multi = rsp_multi;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout op=%0d: got no rsp_valid, required within 20 cycles", op);
    end
    @(negedge clk);
    r_dirty = rsp_valid | rsp_hit | rsp_err | (rsp_addr != 3'd0);
    we_delta = we_cnt - we0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (cam_we !== 8'h00) begin n_fail++; $display("FAIL reset_cam_we got %h want 00", cam_we); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_checks++; if (cam_search_word !== 8'h00 || cam_dont_care_mask !== 8'h00) begin
      n_fail++; $display("FAIL reset_word_mask got %h/%h want 00/00", cam_search_word, cam_dont_care_mask); end
  endtask

  task automatic test_search_empty();
    do_req(SRCH, 3'd0, 8'hA5, 8'h00);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL search_latency got %0d want 3", lat); end
    n_checks++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL search_empty_hit got %b want 0", r_hit); end
    n_checks++; if (r_addr !== 3'd0 || r_err !== 1'b0) begin
      n_fail++; $display("FAIL search_empty_addr_err got %0d/%b want 0/0", r_addr, r_err); end
    n_checks++; if (r_dirty !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse_width got dirty=%b want 0", r_dirty); end
  endtask

  task automatic test_write_search();
    do_req(WR, 3'd3, 8'hA5, 8'h00);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_latency got %0d want 2", lat); end
    n_checks++; if (r_addr !== 3'd3 || r_err !== 1'b0) begin
      n_fail++; $display("FAIL write_rsp got addr=%0d err=%b want 3/0", r_addr, r_err); end
    n_checks++; if (we_delta !== 1) begin n_fail++; $display("FAIL write_we_pulses got %0d want 1", we_delta); end
    n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL write_occupancy got %0d want 1", occupancy); end
    do_req(SRCH, 3'd0, 8'hA5, 8'h00);
    n_checks++; if (r_hit !== 1'b1 || r_addr !== 3'd3) begin
      n_fail++; $display("FAIL search_row3 got hit=%b addr=%0d want 1/3", r_hit, r_addr); end
    n_checks++; if (we_delta !== 0) begin n_fail++; $display("FAIL search_no_we got %0d want 0", we_delta); end
  endtask

  task automatic test_multi_match();
    do_req(WR, 3'd2, 8'h3C, 8'h00);
    do_req(WR, 3'd5, 8'h3C, 8'h00);
    n_checks++; if (occupancy !== 4'd3) begin n_fail++; $display("FAIL multi_occupancy got %0d want 3", occupancy); end
    do_req(SRCH, 3'd0, 8'h3C, 8'h00);
    n_checks++; if (r_hit !== 1'b1 || r_addr !== 3'd2) begin
      n_fail++; $display("FAIL multi_lowest got hit=%b addr=%0d want 1/2", r_hit, r_addr); end
`ifdef CAM_CTRL_MULTI_MATCH_EN
    n_checks++; if (r_multi !== 1'b1) begin n_fail++; $display("FAIL multi_flag got %b want 1", r_multi); end
`endif
    do_req(SRCH, 3'd0, 8'h3D, 8'h01);
    n_checks++; if (r_hit !== 1'b1 || r_addr !== 3'd2) begin
      n_fail++; $display("FAIL masked_search got hit=%b addr=%0d want 1/2", r_hit, r_addr); end
    do_req(SRCH, 3'd0, 8'hA5, 8'h00);
`ifdef CAM_CTRL_MULTI_MATCH_EN
    n_checks++; if (r_multi !== 1'b0) begin n_fail++; $display("FAIL single_flag got %b want 0", r_multi); end
`endif
    do_req(SRCH, 3'd0, 8'h00, 8'hFF);
    n_checks++; if (r_hit !== 1'b1 || r_addr !== 3'd2) begin
      n_fail++; $display("FAIL full_mask_search got hit=%b addr=%0d want 1/2", r_hit, r_addr); end
  endtask

  task automatic test_alloc();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_req(AL, 3'd7, 8'h10 + 8'(i), 8'h00);
      n_checks++; if (r_addr !== 3'(i) || r_err !== 1'b0 || we_delta !== 1) begin
        n_fail++; $display("FAIL alloc_%0d got addr=%0d err=%b we=%0d want %0d/0/1", i, r_addr, r_err, we_delta, i); end
    end
    n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL alloc_occupancy got %0d want 8", occupancy); end
    do_req(AL, 3'd0, 8'hEE, 8'h00);
    n_checks++; if (r_err !== 1'b1 || we_delta !== 0 || lat !== 2) begin
      n_fail++; $display("FAIL alloc_full got err=%b we=%0d lat=%0d want 1/0/2", r_err, we_delta, lat); end
    n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL alloc_sat got %0d want 8", occupancy); end
  endtask

  task automatic test_invalidate();
    do_req(INV, 3'd4, 8'h00, 8'h00);
    n_checks++; if (r_addr !== 3'd4 || r_err !== 1'b0 || lat !== 2 || we_delta !== 0) begin
      n_fail++; $display("FAIL inval_rsp got addr=%0d err=%b lat=%0d we=%0d want 4/0/2/0", r_addr, r_err, lat, we_delta); end
    n_checks++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL inval_occupancy got %0d want 7", occupancy); end
    do_req(SRCH, 3'd0, 8'h14, 8'h00);
    n_checks++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL inval_search got %b want 0", r_hit); end
    do_req(INV, 3'd4, 8'h00, 8'h00);
    n_checks++; if (r_err !== 1'b0 || occupancy !== 4'd7) begin
      n_fail++; $display("FAIL inval_empty got err=%b occ=%0d want 0/7", r_err, occupancy); end
    do_req(AL, 3'd0, 8'h55, 8'h00);
    n_checks++; if (r_addr !== 3'd4 || r_err !== 1'b0 || occupancy !== 4'd8) begin
      n_fail++; $display("FAIL realloc got addr=%0d err=%b occ=%0d want 4/0/8", r_addr, r_err, occupancy); end
    do_req(SRCH, 3'd0, 8'h14, 8'h00);
    n_checks++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL stale_word got %b want 0", r_hit); end
    do_req(WR, 3'd4, 8'h14, 8'h00);
    n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL overwrite_occ got %0d want 8", occupancy); end
    do_req(SRCH, 3'd0, 8'h14, 8'h00);
    n_checks++; if (r_hit !== 1'b1 || r_addr !== 3'd4) begin
      n_fail++; $display("FAIL rewritten got hit=%b addr=%0d want 1/4", r_hit, r_addr); end
    n_checks++; if (we_multi_hot !== 0) begin n_fail++; $display("FAIL we_onehot got %0d multi-hot pulses want 0", we_multi_hot); end
  endtask

  task automatic test_reset_mid_search();
    int seen;
    seen = 0;
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_op = SRCH; req_word = 8'h12; req_mask = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_rsp got %0d pulses want 0", seen); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL abort_occupancy got %0d want 0", occupancy); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", req_ready); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 3'd0; req_word = 8'h00; req_mask = 8'h00;
    test_reset();
    test_search_empty();
    test_write_search();
    test_multi_match();
    test_alloc();
    test_invalidate();
    test_reset_mid_search();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
